// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with flush-to-bubble and a saturating stall counter.
// Optional PIPE_SKID_EN adds one skid entry so in_ready no longer depends on out_ready.
module pipe_stage_buf #(
  parameter int               WIDTH      = 41,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_consume;

  assign w_accept  = in_valid & w_in_ready;
  assign w_consume = r_out_valid & out_ready;

  // Counter is deliberately untouched by flush so stall statistics survive redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

`ifdef PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  assign w_in_ready = ~r_skid_valid & ~flush;

  // Skid only fills while the main register is stalled, so it is always the younger entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= BUBBLE_VAL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE_VAL;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= BUBBLE_VAL;
      r_skid_valid <= 1'b0;
    end else if (w_consume && r_skid_valid) begin
      r_out_data   <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else if (w_accept && r_out_valid && !out_ready) begin
      r_skid_data  <= in_data;
      r_skid_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_data  <= in_data;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end
`else
  assign w_in_ready = (~r_out_valid | out_ready) & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= BUBBLE_VAL;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= BUBBLE_VAL;
    end else if (w_accept) begin
      r_out_data  <= in_data;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed table, hand sequences and random traffic against a queue model.
module tb_pipe_stage_buf;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [40:0] BUB = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [40:0] in_data, out_data;
  logic [15:0] stall_cnt;

  logic        s_reset, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [7:0]  s_in_data, s_out_data;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .BUBBLE_VAL(8'h3C), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .flush(s_flush),
    .stall_cnt(s_stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ordered queue of held payloads plus the value currently shown on out_data.
  logic [40:0] mq[$];
  logic [40:0] m_shown;
  int unsigned m_cnt;

  function automatic bit m_ir(input bit ordy, input bit fl);
    if (fl) return 1'b0;
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || ordy;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_shown = BUB;
    m_cnt   = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ir"},  64'(in_ready),  64'(m_ir(out_ready, flush)));
    chk({tag, "_ov"},  64'(out_valid), 64'(mq.size() > 0));
    chk({tag, "_od"},  64'(out_data),  64'(m_shown));
    chk({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic drive(input bit iv, input logic [40:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic tick();
    bit acc, cons, stl, fl;
    acc  = in_valid && m_ir(out_ready, flush);
    cons = (mq.size() > 0) && out_ready;
    stl  = (mq.size() > 0) && !out_ready;
    fl   = flush;
    @(posedge clk);
    if (stl && m_cnt < 65535) m_cnt++;
    if (fl) begin
      mq.delete();
      m_shown = BUB;
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_shown = mq[0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          iv;
    logic [40:0] d;
    bit          ordy;
    bit          fl;
    bit          e_ir;
    bit          e_ov;
    logic [40:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit iv, input logic [40:0] d, input bit ordy, input bit fl,
                              input bit ir, input bit ov, input logic [40:0] od, input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    // expected values are what the outputs show during the row, before its clock edge
    vecs[0]  = mk(1'b1, 41'h1,  1'b1, 1'b0, 1'b1, 1'b0, 41'h0, 16'd0);
    vecs[1]  = mk(1'b1, 41'h2,  1'b1, 1'b0, 1'b1, 1'b1, 41'h1, 16'd0);
    vecs[2]  = mk(1'b1, 41'h3,  1'b1, 1'b0, 1'b1, 1'b1, 41'h2, 16'd0);
    vecs[3]  = mk(1'b1, 41'h4,  1'b1, 1'b0, 1'b1, 1'b1, 41'h3, 16'd0);
    vecs[4]  = mk(1'b0, 41'h0,  1'b1, 1'b0, 1'b1, 1'b1, 41'h4, 16'd0);
    vecs[5]  = mk(1'b0, 41'h0,  1'b1, 1'b0, 1'b1, 1'b0, 41'h4, 16'd0);
    vecs[6]  = mk(1'b1, 41'h7,  1'b0, 1'b0, 1'b1, 1'b0, 41'h4, 16'd0);
    vecs[7]  = mk(1'b0, 41'h0,  1'b0, 1'b0, SKID, 1'b1, 41'h7, 16'd0);
    vecs[8]  = mk(1'b1, 41'h9,  1'b0, 1'b1, 1'b0, 1'b1, 41'h7, 16'd1);
    vecs[9]  = mk(1'b0, 41'h0,  1'b0, 1'b0, 1'b1, 1'b0, BUB,   16'd2);
    vecs[10] = mk(1'b1, 41'hA,  1'b1, 1'b0, 1'b1, 1'b0, BUB,   16'd2);
    vecs[11] = mk(1'b0, 41'h0,  1'b1, 1'b0, 1'b1, 1'b1, 41'hA, 16'd2);
    vecs[12] = mk(1'b0, 41'h0,  1'b1, 1'b0, 1'b1, 1'b0, 41'hA, 16'd2);

    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    s_reset = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0;
    model_reset();

    // reset held three cycles, then idle
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ov",  64'(out_valid), 64'(0));
    chk("rst_od",  64'(out_data),  64'(BUB));
    chk("rst_cnt", 64'(stall_cnt), 64'(0));
    chk("sat_rst_od", 64'(s_out_data), 64'(8'h3C));
    reset = 1'b1;
    s_reset = 1'b1;
    repeat (2) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      check_model("idle");
      tick();
    end

    // streaming, hold, flush while stalled, recovery
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("tab%0d_ir", i),  64'(in_ready),  64'(vecs[i].e_ir));
      chk($sformatf("tab%0d_ov", i),  64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("tab%0d_od", i),  64'(out_data),  64'(vecs[i].e_od));
      chk($sformatf("tab%0d_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_cnt));
      tick();
    end

    // back-pressure: 0xA5 held for five stalled cycles, 0x5A follows
    do_reset();
    drive(1'b1, 41'hA5, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 41'h5A, 1'b0, 1'b0);
      check_model("bp");
      chk("bp_ir", 64'(in_ready), 64'((SKID && i == 0) ? 1 : 0));
      tick();
    end
    drive(1'b1, 41'h5A, 1'b1, 1'b0);
    chk("bp_od_first", 64'(out_data),  64'(41'hA5));
    chk("bp_cnt5",     64'(stall_cnt), 64'(5));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_od_second", 64'(out_data),  64'(41'h5A));
    chk("bp_ov_second", 64'(out_valid), 64'(1));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    check_model("bp_drain");
    tick();

    // flush while full and stalled
    drive(1'b1, 41'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 41'h78, 1'b0, 1'b0); tick();
    drive(1'b1, 41'h99, 1'b0, 1'b1);
    chk("fl_ir_during", 64'(in_ready), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fl_ov",  64'(out_valid), 64'(0));
    chk("fl_od",  64'(out_data),  64'(BUB));
    chk("fl_ir",  64'(in_ready),  64'(1));
    chk("fl_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("fl_cnt_kept", 64'(stall_cnt != 0), 64'(1));
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [63:0] r64;
      r64 = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), r64[40:0], ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
      check_model("rnd");
      tick();
    end

    // async reset between edges during a stall
    drive(1'b1, 41'h33, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("areset_ov",  64'(out_valid), 64'(0));
    chk("areset_od",  64'(out_data),  64'(BUB));
    chk("areset_cnt", 64'(stall_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // saturation on the 4-bit counter instance
    @(negedge clk);
    s_in_valid = 1'b1; s_in_data = 8'h81; s_out_ready = 1'b0;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      chk($sformatf("sat_cnt%0d", k + 1), 64'(s_stall_cnt), 64'((k + 1 > 15) ? 15 : k + 1));
    end
    chk("sat_od", 64'(s_out_data), 64'(8'h81));
    s_flush = 1'b1;
    @(negedge clk); #1;
    s_flush = 1'b0;
    chk("sat_fl_ov",  64'(s_out_valid), 64'(0));
    chk("sat_fl_od",  64'(s_out_data),  64'(8'h3C));
    chk("sat_fl_cnt", 64'(s_stall_cnt), 64'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
